// File: rtl/conv_layer_input_ctrl.sv
// Row-by-row image reader that fills the convolution input buffer and steps it through SHIFT/BIAS.
// Optional `CONV_INPUT_CTRL_STALL_EN adds a stall input that freezes the sequencer.
module conv_layer_input_ctrl #(
    parameter int BUFFER_ROW = 3,
    parameter int BUFFER_COL = 8,
    parameter int IMAGE_ROW  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ROW_W      = $clog2(BUFFER_ROW + 1),
    parameter int COL_W      = $clog2(BUFFER_COL + 1),
    parameter int ADDR_W     = $clog2(IMAGE_ROW * BUFFER_COL + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef CONV_INPUT_CTRL_STALL_EN
    input  logic                  stall,
`endif
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic [COL_W-1:0]      col_index,
    output logic [ROW_W-1:0]      row_index,
    output logic [ROW_W-1:0]      preload_cycle,
    output logic [2:0]            current_state,
    output logic                  done
);

    localparam int SHIFT_LEN = (BUFFER_COL - BUFFER_ROW + 1) * BUFFER_ROW;
    localparam int SH_W      = $clog2(SHIFT_LEN + 1);
    localparam int IMG_W     = $clog2(IMAGE_ROW + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SHIFT = 3'd2;
    localparam logic [2:0] S_BIAS  = 3'd3;

    logic [2:0]        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [IMG_W-1:0]  img_row_q, img_row_d;
    logic [ROW_W-1:0]  pre_q, pre_d;
    logic [ROW_W-1:0]  ridx_q, ridx_d;
    logic [SH_W-1:0]   sh_q, sh_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic [2:0]        cur_state_q;
    logic [COL_W-1:0]  col_out_q;
    logic [ROW_W-1:0]  ridx_out_q;
    logic [ROW_W-1:0]  pre_out_q;
    logic              done_q;

    logic hold;
    logic preloading;

`ifdef CONV_INPUT_CTRL_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign preloading = (img_row_q < IMG_W'(BUFFER_ROW));

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        img_row_d = img_row_q;
        pre_d     = pre_q;
        ridx_d    = ridx_q;
        sh_d      = sh_q;
        addr_d    = addr_q;
        if (!hold) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d   = S_LOAD;
                        col_d     = '0;
                        img_row_d = '0;
                        pre_d     = '0;
                        ridx_d    = '0;
                        sh_d      = '0;
                        addr_d    = '0;
                    end
                end
                S_LOAD: begin
                    // The address runs straight through row boundaries, so it is a plain counter.
                    addr_d = addr_q + ADDR_W'(1);
                    if (col_q == COL_W'(BUFFER_COL - 1)) begin
                        col_d     = '0;
                        img_row_d = img_row_q + IMG_W'(1);
                        if (preloading && (pre_q != ROW_W'(BUFFER_ROW - 1))) begin
                            pre_d = pre_q + ROW_W'(1);
                        end else begin
                            pre_d   = '0;
                            state_d = S_SHIFT;
                            sh_d    = '0;
                            ridx_d  = '0;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
                S_SHIFT: begin
                    sh_d   = sh_q + SH_W'(1);
                    ridx_d = (ridx_q == ROW_W'(BUFFER_ROW - 1)) ? '0 : ridx_q + ROW_W'(1);
                    if (sh_q == SH_W'(SHIFT_LEN - 1)) begin
                        state_d = S_BIAS;
                        sh_d    = '0;
                    end
                end
                S_BIAS: begin
                    state_d = (img_row_q < IMG_W'(IMAGE_ROW)) ? S_LOAD : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            img_row_q   <= '0;
            pre_q       <= '0;
            ridx_q      <= '0;
            sh_q        <= '0;
            addr_q      <= '0;
            cur_state_q <= S_IDLE;
            col_out_q   <= '0;
            ridx_out_q  <= '0;
            pre_out_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            img_row_q   <= img_row_d;
            pre_q       <= pre_d;
            ridx_q      <= ridx_d;
            sh_q        <= sh_d;
            addr_q      <= addr_d;
            // A stalled cycle is shown as IDLE so the buffer does not act on it.
            cur_state_q <= hold ? S_IDLE : state_q;
            col_out_q   <= col_q;
            ridx_out_q  <= ridx_q;
            pre_out_q   <= pre_q;
            done_q      <= (state_q == S_IDLE) && (cur_state_q == S_BIAS);
        end
    end

    assign rd_en         = (state_q == S_LOAD) && !hold;
    assign rd_addr       = rd_en ? addr_q : '0;
    assign data_in       = rd_data;
    assign col_index     = col_out_q;
    assign row_index     = ridx_out_q;
    assign preload_cycle = pre_out_q;
    assign current_state = cur_state_q;
    assign done          = done_q;

endmodule

// File: tb/tb_conv_layer_input_ctrl.sv
// Randomised bench for conv_layer_input_ctrl: a full-height instance and an IMAGE_ROW=BUFFER_ROW instance
// checked every cycle against a per-cycle timeline built from nested row/column loops.
module tb_conv_layer_input_ctrl;

    localparam int BR = 3;
    localparam int BC = 8;
    localparam int IR_A = 8;
    localparam int IR_B = 3;
    localparam int DW = 8;
    localparam int ROW_W = $clog2(BR + 1);
    localparam int COL_W = $clog2(BC + 1);
    localparam int ADDR_A = $clog2(IR_A * BC + 1);
    localparam int ADDR_B = $clog2(IR_B * BC + 1);
    localparam int SH = (BC - BR + 1) * BR;
    localparam int MAXC = 4096;
    localparam int ST_IDLE = 0, ST_LOAD = 1, ST_SHIFT = 2, ST_BIAS = 3;

    typedef struct {
        int st;
        bit stl;
        int addr;
        int col;
        int ri;
        int pc;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, stall_a, stall_b;
    logic              rd_en_a, rd_en_b, done_a, done_b;
    logic [ADDR_A-1:0] rd_addr_a;
    logic [ADDR_B-1:0] rd_addr_b;
    logic [DW-1:0]     rd_data_a, rd_data_b, data_in_a, data_in_b;
    logic [COL_W-1:0]  col_a, col_b;
    logic [ROW_W-1:0]  row_a, row_b, pre_a, pre_b;
    logic [2:0]        st_a, st_b;

    conv_layer_input_ctrl #(.BUFFER_ROW(BR), .BUFFER_COL(BC), .IMAGE_ROW(IR_A), .DATA_WIDTH(DW)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef CONV_INPUT_CTRL_STALL_EN
        .stall(stall_a),
`endif
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .data_in(data_in_a),
        .col_index(col_a), .row_index(row_a), .preload_cycle(pre_a),
        .current_state(st_a), .done(done_a)
    );

    conv_layer_input_ctrl #(.BUFFER_ROW(BR), .BUFFER_COL(BC), .IMAGE_ROW(IR_B), .DATA_WIDTH(DW)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start),
`ifdef CONV_INPUT_CTRL_STALL_EN
        .stall(stall_b),
`endif
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .data_in(data_in_b),
        .col_index(col_b), .row_index(row_b), .preload_cycle(pre_b),
        .current_state(st_b), .done(done_b)
    );

    logic [DW-1:0] mem_a [IR_A*BC];
    logic [DW-1:0] mem_b [IR_B*BC];
    always @(posedge clk) if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
    always @(posedge clk) if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];

    // Expected internal activity of each instance, indexed by cycle (cycle n follows posedge n).
    ent_t tl [2][MAXC];
    bit   stl_a [MAXC];
    int   cyc = 0;
    int   errors = 0, checks = 0;
    int   stk, stl_len;
    int   fill_inst, fill_pos, fill_idx, fill_sk, fill_sl;
    int   last_len [2];
    int   first_done [2];
    int   done_cnt [2];
    bit   tally = 0;
    int   bias_cnt = 0, rd_cnt = 0, last_addr = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic put(input int st, input int addr, input int col, input int ri, input int pc);
        if (fill_idx == fill_sk) begin
            for (int s = 0; s < fill_sl; s++) begin
                if (fill_pos < MAXC) begin
                    tl[fill_inst][fill_pos] = '{st, 1'b1, addr, col, ri, pc};
                    if (fill_inst == 0) stl_a[fill_pos] = 1'b1;
                end
                fill_pos++;
            end
        end
        if (fill_pos < MAXC) tl[fill_inst][fill_pos] = '{st, 1'b0, addr, col, ri, pc};
        fill_pos++;
        fill_idx++;
    endtask

    task automatic shift_bias();
        for (int k = 0; k < SH; k++) put(ST_SHIFT, 0, 0, k % BR, 0);
        put(ST_BIAS, 0, 0, 0, 0);
    endtask

    task automatic fill(input int inst, input int n0, input int nrows, input int sk, input int sl);
        fill_inst = inst; fill_pos = n0; fill_idx = 0; fill_sk = sk; fill_sl = sl;
        for (int p = 0; p < BR; p++)
            for (int c = 0; c < BC; c++) put(ST_LOAD, p * BC + c, c, 0, p);
        shift_bias();
        for (int r = BR; r < nrows; r++) begin
            for (int c = 0; c < BC; c++) put(ST_LOAD, r * BC + c, c, 0, 0);
            shift_bias();
        end
        last_len[inst] = fill_pos - n0;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        stall_a = stl_a[cyc];
    endtask

    task automatic step(input bit s);
        start = s;
        if (s && rst_n) begin
            if (tl[0][cyc].st == ST_IDLE) begin
                fill(0, cyc + 1, IR_A, stk, stl_len);
                stk = -1;
            end
            if (tl[1][cyc].st == ST_IDLE) fill(1, cyc + 1, IR_B, -1, 0);
        end
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        ent_t z;
        z = '{0, 1'b0, 0, 0, 0, 0};
        rst_n = 1'b0;
        stall_a = 1'b0;
        for (int k = (cyc >= 2 ? cyc - 2 : 0); k < MAXC; k++) begin
            tl[0][k] = z;
            tl[1][k] = z;
            stl_a[k] = 1'b0;
        end
    endtask

    task automatic cmp(input int i, input string p, input logic en, input logic [31:0] addr,
                       input logic [31:0] din, input logic [31:0] col, input logic [31:0] row,
                       input logic [31:0] pre, input logic [31:0] st, input logic dn);
        ent_t e, r, rr;
        bit   exp_en, exp_dn;
        int   exp_din;
        e = tl[i][cyc]; r = tl[i][cyc-1]; rr = tl[i][cyc-2];
        exp_en = (e.st == ST_LOAD) && !e.stl;
        chk({p, ".rd_en"}, en, exp_en);
        if (exp_en) chk({p, ".rd_addr"}, addr, e.addr);
        chk({p, ".current_state"}, st, r.stl ? ST_IDLE : r.st);
        if (!r.stl) begin
            chk({p, ".col_index"}, col, r.col);
            chk({p, ".row_index"}, row, r.ri);
            chk({p, ".preload_cycle"}, pre, r.pc);
        end
        if (r.st == ST_LOAD && !r.stl) begin
            exp_din = (i == 0) ? mem_a[r.addr] : mem_b[r.addr];
            chk({p, ".data_in"}, din, exp_din);
        end
        exp_dn = (r.st == ST_IDLE) && (rr.st == ST_BIAS) && !rr.stl;
        chk({p, ".done"}, dn, exp_dn);
        if (dn === 1'b1) begin
            done_cnt[i]++;
            if (first_done[i] < 0) first_done[i] = cyc;
        end
        if (i == 0 && tally) begin
            if (st === 3'd3) bias_cnt++;
            if (en === 1'b1) begin
                rd_cnt++;
                last_addr = addr;
            end
        end
    endtask

    always @(negedge clk) begin
        if (cyc >= 2) begin
            cmp(0, "A", rd_en_a, rd_addr_a, data_in_a, col_a, row_a, pre_a, st_a, done_a);
            cmp(1, "B", rd_en_b, rd_addr_b, data_in_b, col_b, row_b, pre_b, st_b, done_b);
        end
    end

    initial begin
        int t1, w;
        rst_n = 1'b0; start = 1'b0; stall_a = 1'b0; stall_b = 1'b0;
        stk = -1; stl_len = 0;
`ifdef CONV_INPUT_CTRL_STALL_EN
        stk = BR * BC + SH + 1;
        stl_len = 3;
`endif
        for (int k = 0; k < IR_A * BC; k++) mem_a[k] = DW'($urandom);
        for (int k = 0; k < IR_B * BC; k++) mem_b[k] = DW'($urandom);
        first_done[0] = -1; first_done[1] = -1; done_cnt[0] = 0; done_cnt[1] = 0;

        repeat (3) tick();
        chk("reset.rd_en", rd_en_a, 0);
        chk("reset.rd_addr", rd_addr_a, 0);
        chk("reset.current_state", st_a, 0);
        chk("reset.col_index", col_a, 0);
        chk("reset.done", done_a, 0);
        rst_n = 1'b1;
        repeat (5) step(1'b0);

        // Full frame on both instances, with stray start pulses while busy.
        tally = 1'b1;
        t1 = cyc + 1;
        step(1'b1);
        chk("A.first_rd_en", rd_en_a, 1);
        chk("A.first_rd_addr", rd_addr_a, 0);
        chk("model.len_A", last_len[0], 178 + stl_len);
        chk("model.len_B", last_len[1], 43);
        chk("model.addr23", tl[0][t1+23].addr, 23);
        chk("model.pc23", tl[0][t1+23].pc, 2);
        chk("model.shift24_row", tl[0][t1+25].ri, 1);
        chk("model.bias42", tl[0][t1+42].st, ST_BIAS);
        for (int k = 1; k < 200; k++) step(k < 170 && $urandom_range(0, 15) == 0);
        tally = 1'b0;
        chk("A.done_latency", first_done[0] - t1, 179 + stl_len);
        chk("B.done_latency", first_done[1] - t1, 44);
        chk("A.done_count", done_cnt[0], 1);
        chk("A.bias_cycles", bias_cnt, 6);
        chk("A.read_words", rd_cnt, 64);
        chk("A.last_rd_addr", last_addr, 63);

        // Reset in the middle of a LOAD row.
        step(1'b1);
        w = 0;
        while (!(st_a == 3'd1 && col_a == 4) && w < 100) begin
            step(1'b0);
            w++;
        end
        chk("A.reach_col4", w < 100, 1);
        do_reset();
        #1;
        chk("rst_mid.rd_en", rd_en_a, 0);
        chk("rst_mid.current_state", st_a, 0);
        chk("rst_mid.col_index", col_a, 0);
        tick(); tick();
        rst_n = 1'b1;
        repeat (3) step(1'b0);
        chk("A.idle_after_reset", rd_en_a, 0);

        step(1'b1);
        chk("A.restart_rd_en", rd_en_a, 1);
        chk("A.restart_rd_addr", rd_addr_a, 0);
        for (int k = 0; k < 400; k++) step($urandom_range(0, 11) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_layer_input_ctrl.md
# conv_layer_input_ctrl

Sequencing controller directly upstream of the convolution input row buffer. Reads a single-channel image, row by row, from a synchronous image RAM. Generates the `data_in`, `col_index`, `row_index`, `preload_cycle` and `current_state` stream that fills the buffer and then steps it through the shift and bias phases of every output row. Pulses `done` when the frame is complete.

## Interface
- `BUFFER_ROW`, 3: kernel size; the number of buffered rows (square kernel).
- `BUFFER_COL`, 8: image width in words; the row length of the buffer.
- `IMAGE_ROW`, 8: image height in rows; must be ≥ `BUFFER_ROW`.
- Derived widths:
  - `ROW_W = logb2(BUFFER_ROW)`
  - `COL_W = logb2(BUFFER_COL)`
  - `ADDR_W = logb2(IMAGE_ROW*BUFFER_COL)`
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: single-cycle frame start; ignored unless the controller is idle.
- `rd_en`, out, 1: image RAM read enable.
- `rd_addr`, out, `ADDR_W`: image RAM word address, equal to `row*BUFFER_COL + col`.
- `rd_data`, in, `DATA_WIDTH`: RAM read data; fixed latency of 1 cycle after `rd_en`.
- `data_in`, out, `DATA_WIDTH`: word to the buffer; combinationally equal to `rd_data`.
- `col_index`, out, `COL_W`: column being written in LOAD.
- `row_index`, out, `ROW_W`: buffer row selected for read-out in SHIFT.
- `preload_cycle`, out, `ROW_W`: index of the preload row, 0..`BUFFER_ROW`-1; 0 outside preload.
- `current_state`, out, 3: encoding IDLE=3'd0, LOAD=3'd1, SHIFT=3'd2, BIAS=3'd3; other codes unused.
- `done`, out, 1: one-cycle frame-complete pulse.

## Operation
- The internal FSM (states IDLE, LOAD, SHIFT, BIAS) drives `rd_en` and `rd_addr` directly.
- `current_state`, `col_index`, `row_index` and `preload_cycle` are the internal values registered once. This aligns them with `rd_data`, which returns one cycle after the read.
- **IDLE → LOAD** on `start`. The internal image row counter and `preload_cycle` are cleared.
- **LOAD**:
  - Runs for `BUFFER_COL` cycles, with `col` counting 0..`BUFFER_COL`-1 and `rd_en`=1 on every cycle.
  - At `col`=`BUFFER_COL`-1 the image row counter increments.
  - While preloading (rows 0..`BUFFER_ROW`-1): after `col`=`BUFFER_COL`-1, either increment `preload_cycle` and stay in LOAD, or go to SHIFT once `preload_cycle`=`BUFFER_ROW`-1.
  - After preload, every LOAD loads one row and then goes to SHIFT.
- **SHIFT**:
  - Lasts `(BUFFER_COL-BUFFER_ROW+1)*BUFFER_ROW` cycles; with the defaults this is 6*3 = 18.
  - `row_index` cycles 0,1,..,`BUFFER_ROW`-1 and repeats; `rd_en`=0.
  - Then goes to BIAS.
- **BIAS**: lasts 1 cycle.
  - If the image row counter is below `IMAGE_ROW`, go to LOAD (next row).
  - Otherwise go to IDLE.
- **done**: asserted in the cycle in which registered `current_state` first returns to IDLE after BIAS.
- **start while busy**: ignored; it does not restart or queue a frame.
- **Boundary case**: with `IMAGE_ROW`=`BUFFER_ROW` there is exactly one SHIFT/BIAS pass and no post-preload LOAD.
- **Reset** (asserted at any time, including mid-LOAD):
  - All outputs go to 0, with `current_state`=IDLE.
  - All counters clear.
  - The next frame requires a new `start`.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `col_index`=0, `row_index`=0, `preload_cycle`=0, `current_state`=0, `done`=0.
- `start` sampled at edge t: `rd_en`=1 with `rd_addr`=0 during t+1; registered `current_state`=LOAD with `col_index`=0 during t+2.
- Frame length with the defaults: 24 preload + 6×(18+1) shift/bias + 5×8 load = 178 internal cycles; `done` is seen 179 cycles after the `start` edge.
- `rd_addr` increments by exactly 1 per LOAD cycle across the whole frame; there is no gap at row boundaries.

## Configuration
- `CONV_INPUT_CTRL_STALL_EN`:
  - **Defined**: adds an input `stall` (1 bit).
    - While `stall`=1, the internal FSM and all counters hold, and `rd_en`=0.
    - The registered `current_state` one cycle later is IDLE, so the buffer holds; `col_index`=0 shifts are not repeated.
    - A read issued in the cycle before the stall still completes normally.
  - **Undefined**: no `stall` port; the FSM never pauses.

## Test plan
- Reset, then idle 5 cycles → all outputs 0; `rd_en` never asserted.
- `start` with defaults; RAM holds word = address →
  - `data_in` sees 0..23 with `col_index` 0..7 and `preload_cycle` 0,0..,1..,2;
  - then 18 SHIFT cycles with `row_index` 0,1,2,…; then one BIAS; then LOAD of words 24..31.
- Full frame → exactly 6 BIAS cycles and 8 LOAD passes; last `rd_addr`=63; `done` pulses once at cycle 179; `start` pulses during the frame are ignored.
- `IMAGE_ROW`=3 → preload, 18 SHIFT, 1 BIAS, IDLE; `done` at cycle 44.
- Assert `rst_n`=0 mid-LOAD at `col_index`=4 → outputs 0 next sample; a subsequent `start` restarts at `rd_addr`=0.
- With the stall macro defined: `stall` high for 3 cycles at `col`=0 of the second LOAD → registered state IDLE for 3 cycles; LOAD resumes at the same `rd_addr` with no duplicated or skipped word.
